// File: rtl/rf_multiport.sv
// rf_multiport: multi-read register file with two write ports, a link
// write port, optional same-cycle write-to-read bypass and a per-register
// busy scoreboard. Register 0 is hardwired to zero and is never busy.
module rf_multiport #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 5,
  parameter int unsigned NREAD       = 2,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned LINK_REG    = 31,
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr0_en,
  input  logic [AW-1:0]         wr0_addr,
  input  logic [DW-1:0]         wr0_data,
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [DW-1:0]         wr1_data,
  input  logic                  link_en,
  input  logic [DW-1:0]         link_pc,
  input  logic                  busy_set,
  input  logic [AW-1:0]         busy_addr,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*DW-1:0]   rd_data,
  output logic [NREAD-1:0]      rd_busy,
  output logic [(2**AW)-1:0]    busy_vec
);

  localparam int unsigned NREG      = 2 ** AW;
  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [DW-1:0]   link_data;

  assign link_data = DW'(link_pc + DW'(LINK_OFFSET));

  // Next state: writes applied lowest priority first so link > wr1 > wr0;
  // committed writes clear busy, a new busy_set on the same edge wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_en && (wr0_addr != '0)) begin
      regs_d[wr0_addr] = wr0_data;
      busy_d[wr0_addr] = 1'b0;
    end
    if (wr1_en && (wr1_addr != '0)) begin
      regs_d[wr1_addr] = wr1_data;
      busy_d[wr1_addr] = 1'b0;
    end
    if (link_en && (LINK_ADDR != '0)) begin
      regs_d[LINK_ADDR] = link_data;
      busy_d[LINK_ADDR] = 1'b0;
    end
    if (busy_set && (busy_addr != '0)) begin
      busy_d[busy_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Register array and scoreboard state; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: regs_d already holds the priority-winning write data for
  // any address being written this cycle, so it doubles as the bypass path.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[i*AW +: AW];
    assign rd_data[i*DW +: DW] = (BYPASS != 0) ? regs_d[ra] : regs_q[ra];
    assign rd_busy[i] = busy_q[ra];
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: one instance with bypass, one
// without, both driven from the same stimulus and checked against a model.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr0_en, wr1_en, link_en, busy_set;
  logic [4:0]  wr0_addr, wr1_addr, busy_addr;
  logic [31:0] wr0_data, wr1_data, link_pc;
  logic [9:0]  rd_addr;
  wire  [63:0] rd_data_b, rd_data_n;
  wire  [1:0]  rd_busy_b, rd_busy_n;
  wire  [31:0] busy_vec_b, busy_vec_n;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  rf_multiport #(.BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .link_en(link_en), .link_pc(link_pc),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .busy_vec(busy_vec_b)
  );

  rf_multiport #(.BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .link_en(link_en), .link_pc(link_pc),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .busy_vec(busy_vec_n)
  );

  // Which write (if any) lands in register a this cycle, by priority rule.
  function automatic logic [31:0] win_data(input logic [4:0] a, output bit hit);
    hit = 1'b1;
    if (a == 5'd0)                       begin hit = 1'b0; return 32'h0; end
    if (link_en && a == 5'd31)           return link_pc + 32'd4;
    if (wr1_en && wr1_addr == a)         return wr1_data;
    if (wr0_en && wr0_addr == a)         return wr0_data;
    hit = 1'b0;
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    bit hit;
    logic [31:0] d;
    d = win_data(a, hit);
    if (byp && hit) return d;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_busy = 32'h0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen there.
  task automatic step();
    logic [31:0] nr [32];
    logic [31:0] nb;
    bit hit;
    @(posedge clk);
    nb = m_busy;
    for (int r = 1; r < 32; r++) begin
      nr[r] = win_data(5'(r), hit);
      if (hit) begin m_regs[r] = nr[r]; nb[r] = 1'b0; end
      if (busy_set && busy_addr == 5'(r)) nb[r] = 1'b1;
    end
    m_busy = nb;
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; link_en = 0; busy_set = 0;
    wr0_addr = 0; wr1_addr = 0; busy_addr = 0;
    wr0_data = 0; wr1_data = 0; link_pc = 0;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    rd_addr = {p1, p0};
  endtask

  task automatic test_reset();
    set_rd(5'd5, 5'd0);
    #3;
    vectors++; if (rd_data_b !== 64'h0) begin miscompares++; $display("FAIL reset_rd got %h want 0", rd_data_b); end
    vectors++; if (busy_vec_b !== 32'h0) begin miscompares++; $display("FAIL reset_busy got %h want 0", busy_vec_b); end
    @(negedge clk); rst_n = 1'b1;
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h1234;
    busy_set = 1; busy_addr = 5'd6;
    step(); idle();
    set_rd(5'd5, 5'd6); #1;
    vectors++; if (rd_data_n[31:0] !== 32'h1234) begin miscompares++; $display("FAIL r5_written got %h want 00001234", rd_data_n[31:0]); end
    vectors++; if (busy_vec_n[6] !== 1'b1) begin miscompares++; $display("FAIL r6_busy got %b want 1", busy_vec_n[6]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (rd_data_n[31:0] !== 32'h0) begin miscompares++; $display("FAIL async_reset_n got %h want 0", rd_data_n[31:0]); end
    vectors++; if (rd_data_b[31:0] !== 32'h0) begin miscompares++; $display("FAIL async_reset_b got %h want 0", rd_data_b[31:0]); end
    vectors++; if (busy_vec_n !== 32'h0) begin miscompares++; $display("FAIL async_reset_busy got %h want 0", busy_vec_n); end
    model_reset();
    #2 rst_n = 1'b1;
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    set_rd(5'd0, 5'd0); #1;
    vectors++; if (rd_data_b[31:0] !== 32'h0) begin miscompares++; $display("FAIL r0_bypass got %h want 0", rd_data_b[31:0]); end
    step(); idle(); #1;
    vectors++; if (rd_data_n[31:0] !== 32'h0) begin miscompares++; $display("FAIL r0_write got %h want 0", rd_data_n[31:0]); end
  endtask

  task automatic test_dual_write();
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'hA;
    wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'hB;
    step(); idle();
    set_rd(5'd3, 5'd7); #1;
    vectors++; if (rd_data_n !== {32'hB, 32'hA}) begin miscompares++; $display("FAIL dual_write_n got %h want 0000000b0000000a", rd_data_n); end
    vectors++; if (rd_data_b !== {32'hB, 32'hA}) begin miscompares++; $display("FAIL dual_write_b got %h want 0000000b0000000a", rd_data_b); end
  endtask

  task automatic test_priority();
    wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h2;
    set_rd(5'd9, 5'd9); #1;
    vectors++; if (rd_data_b[31:0] !== 32'h2) begin miscompares++; $display("FAIL prio_bypass got %h want 2", rd_data_b[31:0]); end
    step(); idle(); #1;
    vectors++; if (rd_data_n[31:0] !== 32'h2) begin miscompares++; $display("FAIL prio_wr1 got %h want 2", rd_data_n[31:0]); end
    link_en = 1; link_pc = 32'h0040_0010;
    wr0_en = 1; wr0_addr = 5'd31; wr0_data = 32'h5;
    wr1_en = 1; wr1_addr = 5'd4; wr1_data = 32'h6;
    step(); idle();
    set_rd(5'd31, 5'd4); #1;
    vectors++; if (rd_data_n[31:0] !== 32'h0040_0014) begin miscompares++; $display("FAIL link_prio got %h want 00400014", rd_data_n[31:0]); end
    vectors++; if (rd_data_n[63:32] !== 32'h6) begin miscompares++; $display("FAIL link_other got %h want 6", rd_data_n[63:32]); end
  endtask

  task automatic test_bypass();
    wr0_en = 1; wr0_addr = 5'd12; wr0_data = 32'h55;
    step(); idle();
    wr1_en = 1; wr1_addr = 5'd12; wr1_data = 32'hDEAD;
    set_rd(5'd0, 5'd12); #1;
    vectors++; if (rd_data_b[63:32] !== 32'hDEAD) begin miscompares++; $display("FAIL bypass_on got %h want 0000dead", rd_data_b[63:32]); end
    vectors++; if (rd_data_n[63:32] !== 32'h55) begin miscompares++; $display("FAIL bypass_off_old got %h want 00000055", rd_data_n[63:32]); end
    step(); idle(); #1;
    vectors++; if (rd_data_n[63:32] !== 32'hDEAD) begin miscompares++; $display("FAIL bypass_off_new got %h want 0000dead", rd_data_n[63:32]); end
  endtask

  task automatic test_scoreboard();
    busy_set = 1; busy_addr = 5'd8;
    set_rd(5'd8, 5'd0); #1;
    vectors++; if (rd_busy_b[0] !== 1'b0) begin miscompares++; $display("FAIL busy_no_bypass got %b want 0", rd_busy_b[0]); end
    step(); idle(); #1;
    vectors++; if (rd_busy_b[0] !== 1'b1) begin miscompares++; $display("FAIL busy_set got %b want 1", rd_busy_b[0]); end
    vectors++; if (busy_vec_n !== 32'h100) begin miscompares++; $display("FAIL busy_vec got %h want 00000100", busy_vec_n); end
    wr1_en = 1; wr1_addr = 5'd8; wr1_data = 32'h77;
    step(); idle(); #1;
    vectors++; if (rd_busy_n[0] !== 1'b0) begin miscompares++; $display("FAIL busy_clear got %b want 0", rd_busy_n[0]); end
    busy_set = 1; busy_addr = 5'd8;
    wr0_en = 1; wr0_addr = 5'd8; wr0_data = 32'h88;
    step(); idle(); #1;
    vectors++; if (rd_data_n[31:0] !== 32'h88) begin miscompares++; $display("FAIL set_clear_data got %h want 88", rd_data_n[31:0]); end
    vectors++; if (rd_busy_n[0] !== 1'b1) begin miscompares++; $display("FAIL set_wins got %b want 1", rd_busy_n[0]); end
    busy_set = 1; busy_addr = 5'd0;
    step(); idle(); #1;
    vectors++; if (busy_vec_b[0] !== 1'b0) begin miscompares++; $display("FAIL busy_r0 got %b want 0", busy_vec_b[0]); end
    vectors++; if (rd_busy_b[1] !== 1'b0) begin miscompares++; $display("FAIL rd_busy_r0 got %b want 0", rd_busy_b[1]); end
  endtask

  task automatic test_link_wrap();
    link_en = 1; link_pc = 32'hFFFF_FFFE;
    step(); idle();
    set_rd(5'd31, 5'd0); #1;
    vectors++; if (rd_data_n[31:0] !== 32'h2) begin miscompares++; $display("FAIL link_wrap got %h want 00000002", rd_data_n[31:0]); end
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 31));
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
  endfunction

  task automatic test_random();
    logic [4:0] a;
    for (int n = 0; n < 300; n++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = pick_addr(); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = pick_addr(); wr1_data = $urandom;
      link_en = ($urandom_range(0, 3) == 0); link_pc = $urandom;
      busy_set = 1'($urandom_range(0, 1)); busy_addr = pick_addr();
      set_rd(pick_addr(), pick_addr());
      #1;
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*5 +: 5];
        vectors++;
        if (rd_data_b[p*32 +: 32] !== exp_rd(a, 1'b1)) begin
          miscompares++;
          $display("FAIL rand_rd_b port%0d r%0d got %h want %h", p, a, rd_data_b[p*32 +: 32], exp_rd(a, 1'b1));
        end
        vectors++;
        if (rd_data_n[p*32 +: 32] !== exp_rd(a, 1'b0)) begin
          miscompares++;
          $display("FAIL rand_rd_n port%0d r%0d got %h want %h", p, a, rd_data_n[p*32 +: 32], exp_rd(a, 1'b0));
        end
        vectors++;
        if (rd_busy_b[p] !== m_busy[a] || rd_busy_n[p] !== m_busy[a]) begin
          miscompares++;
          $display("FAIL rand_rd_busy port%0d r%0d got %b/%b want %b", p, a, rd_busy_b[p], rd_busy_n[p], m_busy[a]);
        end
      end
      vectors++;
      if (busy_vec_b !== m_busy || busy_vec_n !== m_busy) begin
        miscompares++;
        $display("FAIL rand_busy_vec got %h/%h want %h", busy_vec_b, busy_vec_n, m_busy);
      end
      step();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    model_reset();
    test_reset();
    test_dual_write();
    test_priority();
    test_bypass();
    test_scoreboard();
    test_link_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-cycle CPU register file. Provides NREAD combinational read ports and two synchronous write ports: wr0 for ALU results and wr1 for load writeback.
- Dedicated link write (PC + LINK_OFFSET into LINK_REG) for jal-type instructions.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for multi-cycle/load producers.
- Sits between decode (read addresses, busy_set) and writeback (write ports).

Parameters:
DW, 32, data width of registers, write data and read data
AW, 5, register address width; register count = 2**AW
NREAD, 2, number of read ports
BYPASS, 1, 1 = read returns same-cycle winning write data; 0 = read returns stored value only
LINK_REG, 31, register index written by the link port
LINK_OFFSET, 4, constant added to link_pc

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr0_en  in  1  write port 0 enable
wr0_addr  in  AW  write port 0 address
wr0_data  in  DW  write port 0 data
wr1_en  in  1  write port 1 enable
wr1_addr  in  AW  write port 1 address
wr1_data  in  DW  write port 1 data
link_en  in  1  write link_pc+LINK_OFFSET to LINK_REG
link_pc  in  DW  current PC
busy_set  in  1  mark busy_addr as pending
busy_addr  in  AW  register to mark pending
rd_addr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
rd_data  out  NREAD*DW  read data; port i at bits [i*DW +: DW]
rd_busy  out  NREAD  busy flag of each read address
busy_vec  out  2**AW  full scoreboard; bit 0 always 0

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - All registers clear to 0.
  - All busy bits clear.
  - Reset overrides any write in flight; writes resume on the first rising edge after rst_n returns high.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and busy_set targeting register 0 are ignored.
- Writes take effect on the rising edge of clk. Link data = (link_pc + LINK_OFFSET) mod 2**DW.
- Write priority when several writes target the same address: link > wr1 > wr0. Writes to distinct addresses in the same cycle all commit.
- Link port conflicts with a regular write to LINK_REG: link wins. A wr0/wr1 to any other address in the same cycle still commits. This differs from the previous generation, where link suppressed all writes.
- Reads are combinational from the stored array.
  - BYPASS=1: if any enabled write targets rd_addr[i] (nonzero) this cycle, rd_data[i] returns the priority-winning write data. Bypass has zero latency.
  - BYPASS=0: the stored value is returned, so a written value is visible the cycle after the edge.
- Scoreboard:
  - At the rising edge, busy_set with nonzero busy_addr sets the busy bit.
  - Any committed write (wr0, wr1 or link) to an address clears its busy bit.
  - Set and clear of the same address in the same cycle: set wins, since a new producer was issued.
- rd_busy[i] = busy_vec[rd_addr[i]] as currently registered; there is no bypass on busy.
- rd_data, rd_busy and busy_vec are purely combinational from state and inputs; no output registers.
- Address arithmetic needs no wrap handling: AW covers the full register range. NREAD ≥ 1.

Test Plan:
- Reset and read-zero:
  - Stimulus: drive rst_n low mid-cycle after writing R5=0x1234.
  - Required response: rd_data of R5 reads 0 immediately, without a clock edge, and busy_vec = 0.
  - Stimulus: write 0xFFFF_FFFF to R0 via wr0.
  - Required response: R0 still reads 0.
- Dual write, distinct addresses:
  - Stimulus: wr0 R3=0xA, wr1 R7=0xB in the same cycle.
  - Required response: next cycle R3=0xA and R7=0xB.
- Same-address priority:
  - Stimulus: wr0 R9=0x1 and wr1 R9=0x2.
  - Required response: R9=0x2.
  - Stimulus: link_en with link_pc=0x0040_0010 plus wr0 R31=0x5 and wr1 R4=0x6.
  - Required response: R31=0x0040_0014 and R4=0x6.
- Bypass:
  - Stimulus: BYPASS=1, wr1 R12=0xDEAD with rd_addr port1=12 in the same cycle.
  - Required response: rd_data port1 = 0xDEAD before the edge.
  - Stimulus: repeat with BYPASS=0.
  - Required response: old value before the edge, 0xDEAD after.
- Scoreboard:
  - Stimulus: busy_set R8.
  - Required response: rd_busy for R8 = 1 next cycle.
  - Stimulus: wr1 R8.
  - Required response: bit clears next cycle.
  - Stimulus: busy_set R8 together with wr0 R8.
  - Required response: R8 data updated and busy remains 1.
  - Stimulus: busy_set R0.
  - Required response: busy_vec bit 0 stays 0.
- Link wrap:
  - Stimulus: link_pc=0xFFFF_FFFE.
  - Required response: R31=0x0000_0002.
